uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Byte-level UART transmitter that serializes one 8-bit word per tx_start pulse onto the tx line, LSB first.
- Sits directly downstream of the tx_control sequencer, which splits 16-bit results into bytes. It consumes that block's tx_start/tx_data and returns tx_busy to pace it.
- Line format is start bit, 8 data bits, optional parity, then 1 or 2 stop bits. Idle line level is 1.

Parameters:
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD, 115200: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated; it must be ≥ 2 (elaboration-time $error otherwise).
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2; any other value is an elaboration error.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- tx_start, input, 1: request to send tx_data; sampled only in IDLE.
- tx_data, input, 8: byte to send; captured on the edge that accepts tx_start.
- tx_busy, output, 1: high from acceptance of a byte until its frame completes.
- tx_done, output, 1: one-cycle pulse at frame completion.
- tx, output, 1: serial line, registered, idle high.

Behaviour:
- Reset (asynchronous assert; release synchronous to clk): state=IDLE, tx=1, tx_busy=0, tx_done=0, shift register=0, baud and bit counters=0.
- States and transitions:
  - IDLE → START when tx_start=1 at a rising edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (if PARITY≠0) or STOP after 8 bit periods.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after STOP_BITS bit periods.
- Acceptance edge, in IDLE with tx_start=1:
  - shift_reg<=tx_data, tx<=0, tx_busy<=1, baud counter cleared.
  - tx is low and tx_busy is high starting the cycle after the accepting edge; there is no extra latency.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1. At terminal count it wraps to 0 and the next bit is driven on the same edge.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - DATA sends shift_reg[0], then shifts right. The bit counter runs 0..7.
- Parity is computed from the captured byte at acceptance and stored. Even: parity bit = XOR of the 8 bits. Odd: parity bit = its inverse.
- STOP drives tx=1.
- Frame completion, on the edge ending the last stop-bit period:
  - state<=IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle, tx stays 1.
- Busy time is CLKS_PER_BIT × (9 + (PARITY≠0) + STOP_BITS) cycles.
- tx_start while busy, including the completion edge itself, is ignored. No queuing, no error flag.
- The earliest next acceptance is the edge after the completion edge. A held-high tx_start therefore gives one extra idle-high clock between frames.
- tx_data changes after acceptance have no effect on the frame in flight.
- A reset mid-frame aborts immediately: tx=1 and tx_busy=0 asynchronously. There is no tx_done for the aborted frame.
- Neither tx nor tx_busy may glitch; both are driven from flops only.

Test Plan:
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000, i.e. 10 clocks/bit.
1. PARITY=0, STOP_BITS=1, pulse tx_start with tx_data=0xA5.
   - tx levels per 10-cycle window: 0, 1,0,1,0,0,1,0,1, 1.
   - tx_busy is high for exactly 100 cycles; one tx_done pulse follows.
2. PARITY=1, then PARITY=2, tx_data=0xA5. Parity-bit window is 0 for even and 1 for odd; busy lasts 110 cycles.
   - Repeat with 0x07: even parity gives 1.
3. STOP_BITS=2, tx_data=0x00. tx is low for 90 cycles, then high for 20; busy lasts 110 cycles.
4. Hold tx_start=1 continuously with tx_data=0x55 then 0xAA.
   - Two back-to-back frames, separated by exactly 11 high cycles (10 stop + 1 idle).
   - tx_start pulses while busy are dropped: 3 extra pulses mid-frame produce no extra frame.
5. Assert reset at cycle 45 of a 0xFF frame. tx=1 and tx_busy=0 without waiting for a clock edge; no tx_done.
   - After release, a new 0x3C frame is bit-exact.
6. Drive it from tx_control with raw_data=0x1234 and one trigger. Line carries byte 0x34 then 0x12, each correctly framed, with no lost or duplicated byte.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One byte per tx_start accepted in IDLE; tx and tx_busy come straight from flops.
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic PAR_INVERT = (PARITY == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic              r_stop;
    logic [7:0]        r_shift;
    logic              r_par;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic w_baud_end;
    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_shift <= tx_data;
                        r_par   <= (^tx_data) ^ PAR_INVERT;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == 3'd7) begin
                            // Parity was fixed at acceptance, so the shifted-out byte is not needed here
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_stop  <= 1'b0;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_tx    <= 1'b1;
                        r_stop  <= 1'b0;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        if (r_stop == STOP_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 10 clocks/bit across four parity/stop configurations.
// Expected line levels are hand-written frame bit strings (start, data LSB first, parity, stop).
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] tb_start;
    logic [7:0] tb_data [4];
    logic [3:0] w_tx, w_busy, w_done;

    int errors = 0;
    int checks = 0;

    logic cap_tx   [0:299];
    logic cap_busy [0:299];
    logic cap_done [0:299];

    always #5 clk = ~clk;

    // Instance 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stop
    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clk(clk), .reset(reset), .tx_start(tb_start[0]), .tx_data(tb_data[0]),
        .tx_busy(w_busy[0]), .tx_done(w_done[0]), .tx(w_tx[0]));
    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .tx_start(tb_start[1]), .tx_data(tb_data[1]),
        .tx_busy(w_busy[1]), .tx_done(w_done[1]), .tx(w_tx[1]));
    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .tx_start(tb_start[2]), .tx_data(tb_data[2]),
        .tx_busy(w_busy[2]), .tx_done(w_done[2]), .tx(w_tx[2]));
    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .clk(clk), .reset(reset), .tx_start(tb_start[3]), .tx_data(tb_data[3]),
        .tx_busy(w_busy[3]), .tx_done(w_done[3]), .tx(w_tx[3]));

    // Pulse tx_start for one edge; returns just after the accepting edge
    task automatic launch(input int k, input logic [7:0] b);
        @(negedge clk);
        tb_data[k]  = b;
        tb_start[k] = 1'b1;
        @(posedge clk);
        #1;
        tb_start[k] = 1'b0;
    endtask

    // Cycle i is sampled at the i-th falling edge after the accepting edge
    task automatic capture(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]   = w_tx[k];
            cap_busy[i] = w_busy[k];
            cap_done[i] = w_done[k];
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tb_start = '0;
        for (int k = 0; k < 4; k++) tb_data[k] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w_tx[k] !== 1'b1 || w_busy[k] !== 1'b0 || w_done[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: tx/busy/done=%b%b%b required 100",
                         k, w_tx[k], w_busy[k], w_done[k]);
            end
        end
        reset = 1'b0;
    endtask

    // One frame on instance k; exp holds nb bit levels, left-aligned
    task automatic test_frame(input string name, input int k, input logic [7:0] b,
                              input logic [0:11] exp, input int nb);
        logic bad;
        int   bl;
        int   dc;
        int   di;
        launch(k, b);
        capture(k, nb * 10 + 20);
        for (int j = 0; j < nb; j++) begin
            bad = 1'b0;
            for (int c = 0; c < 10; c++) if (cap_tx[j*10+c] !== exp[j]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s_bit%0d: tx mid-bit=%b required %b for all 10 cycles",
                         name, j, cap_tx[j*10+5], exp[j]);
            end
        end
        bl = 0;
        while (bl < nb * 10 + 20 && cap_busy[bl] === 1'b1) bl++;
        checks++;
        if (bl != nb * 10) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles required %0d", name, bl, nb * 10);
        end
        dc = 0;
        di = -1;
        for (int i = 0; i < nb * 10 + 20; i++) begin
            if (cap_done[i] === 1'b1) begin
                dc++;
                if (di < 0) di = i;
            end
        end
        checks++;
        if (dc != 1 || di != nb * 10) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses first at %0d required 1 at %0d",
                     name, dc, di, nb * 10);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:9] f1;
        logic [0:9] f2;
        logic       bad;
        int         run;
        int         dc;
        f1 = 10'b0_10101010_1;  // 0x55
        f2 = 10'b0_01010101_1;  // 0xAA
        @(negedge clk);
        tb_data[0]  = 8'h55;
        tb_start[0] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 215; i++) begin
            @(negedge clk);
            cap_tx[i]   = w_tx[0];
            cap_busy[i] = w_busy[0];
            cap_done[i] = w_done[0];
            if (i == 0) tb_data[0] = 8'hAA;
            if (i == 105) tb_start[0] = 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            bad = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (cap_tx[j*10+c] !== f1[j]) bad = 1'b1;
                if (cap_tx[101+j*10+c] !== f2[j]) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL b2b_bit%0d: tx=%b/%b required %b/%b",
                         j, cap_tx[j*10+5], cap_tx[106+j*10], f1[j], f2[j]);
            end
        end
        run = 0;
        while (run < 40 && cap_tx[90+run] === 1'b1) run++;
        checks++;
        if (run != 11) begin
            errors++;
            $display("FAIL b2b_gap: got %0d high cycles required 11", run);
        end
        checks++;
        if (cap_busy[100] !== 1'b0 || cap_busy[101] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy_gap: busy[100..101]=%b%b required 01", cap_busy[100], cap_busy[101]);
        end
        dc = 0;
        for (int i = 0; i < 215; i++) if (cap_done[i] === 1'b1) dc++;
        checks++;
        if (dc != 2 || cap_done[100] !== 1'b1 || cap_done[201] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses required 2 at cycles 100 and 201", dc);
        end
    endtask

    task automatic test_busy_drop();
        int  dc;
        logic bad;
        launch(0, 8'h0F);
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            cap_tx[i]   = w_tx[0];
            cap_busy[i] = w_busy[0];
            cap_done[i] = w_done[0];
            tb_start[0] = (i == 20 || i == 50 || i == 99);
        end
        tb_start[0] = 1'b0;
        bad = 1'b0;
        for (int i = 100; i < 130; i++) if (cap_busy[i] !== 1'b0 || cap_tx[i] !== 1'b1) bad = 1'b1;
        checks++;
        if (cap_busy[99] !== 1'b1 || bad) begin
            errors++;
            $display("FAIL drop_extra_frame: busy[99]=%b, extra activity after cycle 100=%b required 1/0",
                     cap_busy[99], bad);
        end
        dc = 0;
        for (int i = 0; i < 130; i++) if (cap_done[i] === 1'b1) dc++;
        checks++;
        if (dc != 1) begin
            errors++;
            $display("FAIL drop_done: got %0d pulses required 1", dc);
        end
    endtask

    task automatic test_abort();
        int dc;
        int bc;
        launch(0, 8'hFF);
        capture(0, 45);
        checks++;
        if (cap_busy[44] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: busy=%b required 1", cap_busy[44]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: tx/busy=%b%b required 10", w_tx[0], w_busy[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        capture(0, 120);
        dc = 0;
        bc = 0;
        for (int i = 0; i < 120; i++) begin
            if (cap_done[i] === 1'b1) dc++;
            if (cap_busy[i] !== 1'b0 || cap_tx[i] !== 1'b1) bc++;
        end
        checks++;
        if (dc != 0 || bc != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d done pulses and %0d active cycles required 0/0", dc, bc);
        end
        test_frame("after_abort", 0, 8'h3C, 12'b0_00111100_1_00, 10);
    endtask

    // Plays the upstream sequencer: low byte then high byte of 0x1234, paced by tx_busy
    task automatic test_tx_control();
        logic [7:0] exp_b [2];
        logic [7:0] got;
        int         w;
        int         dc;
        exp_b[0] = 8'h34;
        exp_b[1] = 8'h12;
        for (int n = 0; n < 2; n++) begin
            w = 0;
            while (w_busy[0] !== 1'b0 && w < 300) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w >= 300) begin
                errors++;
                $display("FAIL ctl_wait_idle%0d: busy=%b required 0 within 300 cycles", n, w_busy[0]);
            end
            launch(0, exp_b[n]);
            capture(0, 101);
            for (int j = 0; j < 8; j++) got[j] = cap_tx[15+10*j];
            checks++;
            if (cap_tx[5] !== 1'b0 || cap_tx[95] !== 1'b1 || got !== exp_b[n]) begin
                errors++;
                $display("FAIL ctl_byte%0d: start=%b data=%h stop=%b required 0 %h 1",
                         n, cap_tx[5], got, cap_tx[95], exp_b[n]);
            end
            dc = 0;
            for (int i = 0; i < 101; i++) if (cap_done[i] === 1'b1) dc++;
            checks++;
            if (dc != 1 || cap_done[100] !== 1'b1) begin
                errors++;
                $display("FAIL ctl_done%0d: got %0d pulses required 1 at cycle 100", n, dc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame("basic_a5", 0, 8'hA5, 12'b0_10100101_1_00, 10);
        test_frame("even_a5", 1, 8'hA5, 12'b0_10100101_0_1_0, 11);
        test_frame("odd_a5", 2, 8'hA5, 12'b0_10100101_1_1_0, 11);
        test_frame("even_07", 1, 8'h07, 12'b0_11100000_1_1_0, 11);
        test_frame("stop2_00", 3, 8'h00, 12'b0_00000000_1_1_0, 11);
        test_back_to_back();
        test_busy_drop();
        test_abort();
        test_tx_control();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
